// File: rtl/comp_sum_acc_n_if.sv
// Operand/result bus for comp_sum_acc_n: upstream valid/ready, downstream valid/ready, status.
// master = producer/consumer side (bench or neighbours), slave = the arithmetic block.
interface comp_sum_acc_n_if #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] num_A;
  logic [WIDTH-1:0] num_B;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] num_sum;
  logic             cout;
  logic             acc_ovf;
  logic [CNT_W-1:0] op_cnt;

  modport master (
    output in_valid, op, num_A, num_B, cin, out_ready,
    input  in_ready, out_valid, num_sum, cout, acc_ovf, op_cnt
  );

  modport slave (
    input  in_valid, op, num_A, num_B, cin, out_ready,
    output in_ready, out_valid, num_sum, cout, acc_ovf, op_cnt
  );
endinterface

// File: rtl/comp_sum_acc_n.sv
// Registered add/sub/accumulate unit, one-cycle latency, valid/ready on both sides.
// Define COMP_SUM_SAT_EN for saturating results (cout/acc_ovf still report the raw carry).
module comp_sum_acc_n #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  comp_sum_acc_n_if.slave   bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } res_t;

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  op_e              op_w;
  logic [WIDTH:0]   raw;
  res_t             res_d;
  res_t             res_q;
  logic [WIDTH-1:0] acc_q;
  logic             ovf_q;
  logic             vld_q;
  logic [CNT_W-1:0] cnt_q;
  logic             xfer;

  assign op_w         = op_e'(bus.op);
  assign bus.in_ready = !vld_q | bus.out_ready;
  assign xfer         = bus.in_valid & bus.in_ready;

  // Everything runs one bit wider so the top bit is the carry / not-borrow.
  always_comb begin
    raw = '0;
    case (op_w)
      OP_ADD:  raw = {1'b0, bus.num_A} + {1'b0, bus.num_B} + {{WIDTH{1'b0}}, bus.cin};
      OP_SUB:  raw = {1'b0, bus.num_A} + {1'b0, ~bus.num_B} + ONE;
      OP_ACC:  raw = {1'b0, acc_q} + {1'b0, bus.num_A};
      default: raw = '0;
    endcase
  end

  always_comb begin
    res_d.sum  = raw[WIDTH-1:0];
    res_d.cout = raw[WIDTH];
`ifdef COMP_SUM_SAT_EN
    if ((op_w == OP_ADD || op_w == OP_ACC) && raw[WIDTH])
      res_d.sum = '1;
    else if (op_w == OP_SUB && !raw[WIDTH])
      res_d.sum = '0;
`endif
  end

  // All visible state only moves on an accepted transfer, so a stalled result holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      res_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (xfer) begin
      vld_q <= 1'b1;
      res_q <= res_d;
      cnt_q <= cnt_q + 1'b1;
      if (op_w == OP_ACC) begin
        acc_q <= res_d.sum;
        if (raw[WIDTH]) ovf_q <= 1'b1;
      end else if (op_w == OP_CLR) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.num_sum   = res_q.sum;
  assign bus.cout      = res_q.cout;
  assign bus.acc_ovf   = ovf_q;
  assign bus.op_cnt    = cnt_q;

endmodule

// File: tb/tb_comp_sum_acc_n.sv
// Directed bench for comp_sum_acc_n (WIDTH=7, CNT_W=8); expectations follow COMP_SUM_SAT_EN.
module tb_comp_sum_acc_n;

`ifdef COMP_SUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = '0;

  comp_sum_acc_n_if #(.WIDTH(7), .CNT_W(8)) bif ();

  comp_sum_acc_n #(.WIDTH(7), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  // Applies one op at the negedge, returns 1 time unit after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [6:0] a, input logic [6:0] b, input logic c);
    @(negedge clk);
    bif.op = o; bif.num_A = a; bif.num_B = b; bif.cin = c; bif.in_valid = 1'b1;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic test_reset;
    bif.in_valid = 0; bif.out_ready = 1; bif.op = ADD; bif.num_A = 0; bif.num_B = 0; bif.cin = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bif.out_valid !== 1'b0 || bif.num_sum !== 7'h00 || bif.cout !== 1'b0) begin
      errors++; $display("FAIL reset_out: valid=%b sum=%h cout=%b required 0/00/0", bif.out_valid, bif.num_sum, bif.cout); end
    checks++; if (bif.acc_ovf !== 1'b0 || bif.op_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_status: ovf=%b cnt=%0d required 0/0", bif.acc_ovf, bif.op_cnt); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bif.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", bif.in_ready); end
    exp_cnt = '0;
  endtask

  task automatic test_add;
    send(ADD, 7'h30, 7'h35, 1'b0);
    checks++; if (bif.out_valid !== 1'b1 || bif.num_sum !== 7'h65 || bif.cout !== 1'b0 || bif.op_cnt !== 8'd1) begin
      errors++; $display("FAIL add_basic: valid=%b sum=%h cout=%b cnt=%0d required 1/65/0/1",
                         bif.out_valid, bif.num_sum, bif.cout, bif.op_cnt); end
    send(ADD, 7'h7F, 7'h01, 1'b0);
    checks++; if (bif.num_sum !== (SAT ? 7'h7F : 7'h00) || bif.cout !== 1'b1) begin
      errors++; $display("FAIL add_carry: sum=%h cout=%b required %h/1", bif.num_sum, bif.cout, SAT ? 7'h7F : 7'h00); end
    send(ADD, 7'h10, 7'h20, 1'b1);
    checks++; if (bif.num_sum !== 7'h31 || bif.cout !== 1'b0) begin
      errors++; $display("FAIL add_cin: sum=%h cout=%b required 31/0", bif.num_sum, bif.cout); end
  endtask

  task automatic test_sub;
    send(SUB, 7'h35, 7'h30, 1'b1);
    checks++; if (bif.num_sum !== 7'h05 || bif.cout !== 1'b1) begin
      errors++; $display("FAIL sub_pos: sum=%h cout=%b required 05/1", bif.num_sum, bif.cout); end
    send(SUB, 7'h30, 7'h35, 1'b0);
    checks++; if (bif.num_sum !== (SAT ? 7'h00 : 7'h7B) || bif.cout !== 1'b0) begin
      errors++; $display("FAIL sub_borrow: sum=%h cout=%b required %h/0", bif.num_sum, bif.cout, SAT ? 7'h00 : 7'h7B); end
  endtask

  task automatic test_acc;
    send(CLR, 7'h55, 7'h2A, 1'b1);
    checks++; if (bif.num_sum !== 7'h00 || bif.cout !== 1'b0 || bif.acc_ovf !== 1'b0) begin
      errors++; $display("FAIL acc_clr0: sum=%h cout=%b ovf=%b required 00/0/0", bif.num_sum, bif.cout, bif.acc_ovf); end
    send(ACC, 7'h40, 7'h11, 1'b1);
    checks++; if (bif.num_sum !== 7'h40 || bif.cout !== 1'b0 || bif.acc_ovf !== 1'b0) begin
      errors++; $display("FAIL acc_first: sum=%h cout=%b ovf=%b required 40/0/0", bif.num_sum, bif.cout, bif.acc_ovf); end
    send(ACC, 7'h40, 7'h22, 1'b0);
    checks++; if (bif.num_sum !== (SAT ? 7'h7F : 7'h00) || bif.cout !== 1'b1 || bif.acc_ovf !== 1'b1) begin
      errors++; $display("FAIL acc_ovf: sum=%h cout=%b ovf=%b required %h/1/1",
                         bif.num_sum, bif.cout, bif.acc_ovf, SAT ? 7'h7F : 7'h00); end
    send(ADD, 7'h01, 7'h01, 1'b0);
    checks++; if (bif.num_sum !== 7'h02 || bif.acc_ovf !== 1'b1) begin
      errors++; $display("FAIL acc_sticky: sum=%h ovf=%b required 02/1", bif.num_sum, bif.acc_ovf); end
    send(CLR, 7'h00, 7'h00, 1'b0);
    checks++; if (bif.num_sum !== 7'h00 || bif.cout !== 1'b0 || bif.acc_ovf !== 1'b0) begin
      errors++; $display("FAIL acc_clr1: sum=%h cout=%b ovf=%b required 00/0/0", bif.num_sum, bif.cout, bif.acc_ovf); end
    send(ACC, 7'h07, 7'h00, 1'b0);
    checks++; if (bif.num_sum !== 7'h07 || bif.op_cnt !== exp_cnt) begin
      errors++; $display("FAIL acc_after_clr: sum=%h cnt=%0d required 07/%0d", bif.num_sum, bif.op_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure;
    @(negedge clk); bif.in_valid = 1'b0; bif.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bif.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: out_valid=%b required 0", bif.out_valid); end
    bif.out_ready = 1'b0; bif.op = ADD; bif.num_A = 7'h11; bif.num_B = 7'h22; bif.cin = 1'b0; bif.in_valid = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bif.out_valid !== 1'b1 || bif.in_ready !== 1'b0 || bif.num_sum !== 7'h33 || bif.op_cnt !== exp_cnt) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b rdy=%b sum=%h cnt=%0d required 1/0/33/%0d",
                           i, bif.out_valid, bif.in_ready, bif.num_sum, bif.op_cnt, exp_cnt); end
      @(negedge clk); bif.num_A = 7'(i * 9 + 1); bif.op = SUB;
    end
    bif.out_ready = 1'b1; bif.op = ADD; bif.num_A = 7'h01; bif.num_B = 7'h02;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 8'd1;
    checks++; if (bif.out_valid !== 1'b1 || bif.num_sum !== 7'h03 || bif.op_cnt !== exp_cnt) begin
      errors++; $display("FAIL bp_swap: valid=%b sum=%h cnt=%0d required 1/03/%0d",
                         bif.out_valid, bif.num_sum, bif.op_cnt, exp_cnt); end
    @(negedge clk); bif.in_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] s;
    logic [6:0] a, b, e;
    int bad;
    bad = 0;
    @(negedge clk); rst_n = 1'b0; #1 rst_n = 1'b1;
    bif.out_ready = 1'b1; bif.op = ADD; bif.cin = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a = 7'(i); b = 7'(i * 3);
      bif.num_A = a; bif.num_B = b; bif.in_valid = 1'b1;
      @(posedge clk); #1;
      s = {1'b0, a} + {1'b0, b};
      e = (SAT && s[7]) ? 7'h7F : s[6:0];
      if (bif.out_valid !== 1'b1 || bif.num_sum !== e || bif.cout !== s[7]) begin
        bad++;
        if (bad < 4) $display("FAIL b2b[%0d]: valid=%b sum=%h cout=%b required 1/%h/%b",
                              i, bif.out_valid, bif.num_sum, bif.cout, e, s[7]);
      end
    end
    @(negedge clk); bif.in_valid = 1'b0;
    checks++; if (bad != 0) errors++;
    checks++; if (bif.op_cnt !== 8'd44) begin
      errors++; $display("FAIL cnt_wrap: op_cnt=%0d required 44", bif.op_cnt); end
  endtask

  task automatic test_reset_mid;
    send(CLR, 7'h00, 7'h00, 1'b0);
    send(ACC, 7'h40, 7'h00, 1'b0);
    checks++; if (bif.out_valid !== 1'b1 || bif.num_sum !== 7'h40 || bif.op_cnt !== 8'd46) begin
      errors++; $display("FAIL mid_pre: valid=%b sum=%h cnt=%0d required 1/40/46", bif.out_valid, bif.num_sum, bif.op_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bif.out_valid !== 1'b0 || bif.num_sum !== 7'h00 || bif.acc_ovf !== 1'b0 || bif.op_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_async: valid=%b sum=%h ovf=%b cnt=%0d required 0/00/0/0",
                         bif.out_valid, bif.num_sum, bif.acc_ovf, bif.op_cnt); end
    @(negedge clk); rst_n = 1'b1;
    exp_cnt = '0;
    send(ACC, 7'h05, 7'h00, 1'b0);
    checks++; if (bif.num_sum !== 7'h05 || bif.acc_ovf !== 1'b0 || bif.op_cnt !== 8'd1) begin
      errors++; $display("FAIL mid_after: sum=%h ovf=%b cnt=%0d required 05/0/1", bif.num_sum, bif.acc_ovf, bif.op_cnt); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_acc();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
